pipeline_hazard_controller: RTL

//  Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives the enable and

---
 rtl/pipeline_hazard_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: turns load-use, branch,
// data-memory wait and divider hazards into per-stage enable/flush controls.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Load_use_hazard,
  input  logic             Branch_taken,
  input  logic             Mem_req,
  input  logic             Mem_ready,
  input  logic             Div_start,
  input  logic             Div_done,
  output logic             PC_enable,
  output logic             IF_ID_enable,
  output logic             IF_ID_flush,
  output logic             ID_EX_enable,
  output logic             ID_EX_flush,
  output logic             EX_MEM_enable,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_enable,
  output logic             MEM_WB_flush,
  output logic             Mem_error,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] Stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_DIV_WAIT = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_MEM_HOLD,
    ACT_MEM_TIMEOUT,
    ACT_DIV_HOLD,
    ACT_BRANCH,
    ACT_LOAD_USE
  } action_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [CNT_W-1:0]  stall_q;
  action_t           action;
  logic              mem_stall;
  logic              div_stall;
  logic              timeout_hit;

  assign mem_stall   = Mem_req & ~Mem_ready;
  assign div_stall   = Div_start & ~Div_done;
  assign timeout_hit = (wait_q >= WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // One winning hazard per cycle; each state only considers the rules still open to it.
  always_comb begin
    action = ACT_ADVANCE;
    case (state_q)
      ST_RUN: begin
        if (mem_stall)            action = ACT_MEM_HOLD;
        else if (div_stall)       action = ACT_DIV_HOLD;
        else if (Branch_taken)    action = ACT_BRANCH;
        else if (Load_use_hazard) action = ACT_LOAD_USE;
      end
      ST_MEM_WAIT: begin
        if (!Mem_ready)           action = timeout_hit ? ACT_MEM_TIMEOUT : ACT_MEM_HOLD;
        else if (div_stall)       action = ACT_DIV_HOLD;
        else if (Branch_taken)    action = ACT_BRANCH;
        else if (Load_use_hazard) action = ACT_LOAD_USE;
      end
      ST_DIV_WAIT: begin
        if (!Div_done)            action = ACT_DIV_HOLD;
        else if (Branch_taken)    action = ACT_BRANCH;
        else if (Load_use_hazard) action = ACT_LOAD_USE;
      end
      default:                    action = ACT_ADVANCE;
    endcase
  end

  always_comb begin
    state_d = ST_RUN;
    wait_d  = '0;
    case (action)
      ACT_MEM_HOLD: begin
        state_d = ST_MEM_WAIT;
        wait_d  = (state_q == ST_MEM_WAIT) ? wait_q + WAIT_W'(1) : WAIT_W'(1);
      end
      ACT_DIV_HOLD: state_d = ST_DIV_WAIT;
      default:      state_d = ST_RUN;
    endcase
  end

  // A flush always comes with its enable set so the bubble is actually loaded.
  always_comb begin
    PC_enable     = 1'b1;
    IF_ID_enable  = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_enable  = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_enable = 1'b1;
    EX_MEM_flush  = 1'b0;
    MEM_WB_enable = 1'b1;
    MEM_WB_flush  = 1'b0;
    Mem_error     = 1'b0;
    case (action)
      ACT_MEM_HOLD: begin
        PC_enable     = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_enable  = 1'b0;
        EX_MEM_enable = 1'b0;
        MEM_WB_flush  = 1'b1;
      end
      ACT_MEM_TIMEOUT: begin
        PC_enable     = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_enable  = 1'b0;
        EX_MEM_flush  = 1'b1;
        MEM_WB_flush  = 1'b1;
        Mem_error     = 1'b1;
      end
      ACT_DIV_HOLD: begin
        PC_enable     = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_enable  = 1'b0;
        EX_MEM_flush  = 1'b1;
      end
      ACT_BRANCH: begin
        IF_ID_flush   = 1'b1;
        ID_EX_flush   = 1'b1;
      end
      ACT_LOAD_USE: begin
        PC_enable     = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_flush   = 1'b1;
      end
      default: ;
    endcase
    if (!Reset) begin
      PC_enable     = 1'b0;
      IF_ID_enable  = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_enable  = 1'b0;
      ID_EX_flush   = 1'b0;
      EX_MEM_enable = 1'b0;
      EX_MEM_flush  = 1'b0;
      MEM_WB_enable = 1'b0;
      MEM_WB_flush  = 1'b0;
      Mem_error     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      stall_q <= '0;
    else if (!PC_enable && !(&stall_q))
      stall_q <= stall_q + CNT_W'(1);
  end

  assign State       = state_q;
  assign Stall_count = stall_q;

endmodule
